lcd_controller: RTL and testbench

- Memory-mapped HD44780 character-LCD peripheral on the 6502 bus. It sits alongside interface_adapter in the 0x0810–0x081F decode window and drives the board LCD pins.
- A small write FIFO decouples CPU byte writes from slow LCD bus timing, so firmware can write without polling.
- An internal FSM runs the power-up init sequence, then generates the RS/EN/data timing for each queued byte.

---
 rtl/lcd_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_lcd_controller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_controller.sv
// HD44780 character-LCD peripheral for the 6502 bus.
// CPU writes are queued as {rs, byte} in a small FIFO; a timing FSM runs
// the power-up init sequence, then turns each queued byte into an
// RS/data setup, an EN strobe and a post-command wait.
module lcd_controller #(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int SETUP_CYCLES      = 2,
    parameter int EN_CYCLES         = 12,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chip_en,
    input  logic       wrt_en,
    input  logic       register_select,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_on
);

    // Every phase lasts at least one cycle, even if its parameter is 0.
    localparam int POW_N = (POWERUP_CYCLES    > 1) ? POWERUP_CYCLES    : 1;
    localparam int SET_N = (SETUP_CYCLES      > 1) ? SETUP_CYCLES      : 1;
    localparam int EN_N  = (EN_CYCLES         > 1) ? EN_CYCLES         : 1;
    localparam int CMD_N = (CMD_WAIT_CYCLES   > 1) ? CMD_WAIT_CYCLES   : 1;
    localparam int CLR_N = (CLEAR_WAIT_CYCLES > 1) ? CLEAR_WAIT_CYCLES : 1;

    localparam int MAX_A = (POW_N > SET_N) ? POW_N : SET_N;
    localparam int MAX_B = (EN_N  > CMD_N) ? EN_N  : CMD_N;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_C > CLR_N) ? MAX_C : CLR_N;

    // The counter only ever needs to reach MAX_P-1.
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CFW   = PTR_W + 1;

    localparam logic [CNT_W-1:0] POW_LAST = CNT_W'(POW_N - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SET_N - 1);
    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_N  - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_N - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_N - 1);

    localparam logic [CFW-1:0] COUNT_FULL = CFW'(FIFO_DEPTH);
    localparam logic [2:0]     INIT_LEN   = 3'd6;

    localparam logic [2:0] ST_POWERUP_WAIT = 3'd0;
    localparam logic [2:0] ST_INIT_LOAD    = 3'd1;
    localparam logic [2:0] ST_IDLE         = 3'd2;
    localparam logic [2:0] ST_SETUP        = 3'd3;
    localparam logic [2:0] ST_PULSE        = 3'd4;
    localparam logic [2:0] ST_WAIT         = 3'd5;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_data;
    logic             r_rs;
    logic             r_en;

    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CFW-1:0]   r_count;
    logic             r_ovf;

    logic             w_full;
    logic             w_empty;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_ovf_clr;
    logic [8:0]       w_head;
    logic             w_busy;
    logic [2:0]       w_cnt3;
    logic             w_long_wait;
    logic [CNT_W-1:0] w_wait_last;
    logic [7:0]       w_rom_byte;

    assign w_full     = (r_count == COUNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push_req = chip_en && wrt_en;
    // The FSM only drains the FIFO from IDLE, never during init.
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;
    // A full FIFO still accepts a push when a slot frees on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = chip_en && !wrt_en && !register_select;
    assign w_head     = r_mem[r_rd_ptr];

    assign w_busy   = (r_state != ST_IDLE) || !w_empty;
    assign w_cnt3   = 3'(r_count);
    assign data_out = chip_en ? {w_busy, w_full, r_ovf, 2'b00, w_cnt3} : 8'h00;

    // Clear-display and return-home need the long wait; data bytes never do.
    assign w_long_wait = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02));
    assign w_wait_last = w_long_wait ? CLR_LAST : CMD_LAST;

    // Init ROM: 8-bit/2-line function set x3, display on, clear, entry mode.
    always_comb begin
        w_rom_byte = 8'h38;
        case (r_idx)
            3'd3:    w_rom_byte = 8'h0C;
            3'd4:    w_rom_byte = 8'h01;
            3'd5:    w_rom_byte = 8'h06;
            default: w_rom_byte = 8'h38;
        endcase
    end

    // FIFO storage: written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {register_select, data_in};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A dropped byte on the same edge as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Timing FSM. r_cnt counts cycles already spent in the current phase
    // and is cleared on every phase change; lcd_en is high exactly while in PULSE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_POWERUP_WAIT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            case (r_state)
                ST_POWERUP_WAIT: begin
                    if (r_cnt == POW_LAST) begin
                        r_state <= ST_INIT_LOAD;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_INIT_LOAD: begin
                    r_rs    <= 1'b0;
                    r_data  <= w_rom_byte;
                    r_idx   <= r_idx + 1'b1;
                    r_state <= ST_SETUP;
                    r_cnt   <= '0;
                end
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_rs    <= w_head[8];
                        r_data  <= w_head[7:0];
                        r_state <= ST_SETUP;
                        r_cnt   <= '0;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == SET_LAST) begin
                        r_state <= ST_PULSE;
                        r_en    <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == EN_LAST) begin
                        r_state <= ST_WAIT;
                        r_en    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == w_wait_last) begin
                        r_state <= (r_idx < INIT_LEN) ? ST_INIT_LOAD : ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_POWERUP_WAIT;
                    r_cnt   <= '0;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign lcd_data = r_data;
    assign lcd_rs   = r_rs;
    assign lcd_en   = r_en;
    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with short timing parameters.
// Pulse gaps are counted as low-EN samples: WAIT length plus the
// INIT_LOAD/IDLE cycle plus the one SETUP cycle.
module tb_lcd_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       chip_en = 1'b0;
    logic       wrt_en = 1'b0;
    logic       register_select = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_en;
    logic       lcd_rw;
    logic       lcd_on;

    int checks = 0;
    int errors = 0;

    lcd_controller #(
        .POWERUP_CYCLES   (20),
        .SETUP_CYCLES     (1),
        .EN_CYCLES        (2),
        .CMD_WAIT_CYCLES  (5),
        .CLEAR_WAIT_CYCLES(10),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .chip_en        (chip_en),
        .wrt_en         (wrt_en),
        .register_select(register_select),
        .data_in        (data_in),
        .data_out       (data_out),
        .lcd_data       (lcd_data),
        .lcd_rs         (lcd_rs),
        .lcd_en         (lcd_en),
        .lcd_rw         (lcd_rw),
        .lcd_on         (lcd_on)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        chip_en = 1'b1;
        wrt_en = 1'b1;
        register_select = rs;
        data_in = d;
        tick();
        chip_en = 1'b0;
        wrt_en = 1'b0;
        $display("write rs=%0d data=%02h", rs, d);
    endtask

    // Counts low samples (current one included) up to the EN rise, then
    // the high width, checking rs/data stay at the expected values.
    task automatic pulse_seq(input logic exp_rs, input logic [7:0] exp_d,
                             input int exp_low, input string name);
        int low;
        int high;
        int bad;
        low = 0;
        while (lcd_en === 1'b0 && low < 200) begin
            low++;
            tick();
        end
        checks++;
        if (low !== exp_low) begin
            errors++;
            $display("FAIL %s gap: low %0d cycles, expected %0d", name, low, exp_low);
        end
        high = 0;
        bad = 0;
        while (lcd_en === 1'b1 && high < 50) begin
            if (lcd_rs !== exp_rs || lcd_data !== exp_d) bad++;
            high++;
            tick();
        end
        checks++;
        if (bad != 0 || high == 0) begin
            errors++;
            $display("FAIL %s bus: rs=%0d data=%02h during EN, expected rs=%0d data=%02h",
                     name, lcd_rs, lcd_data, exp_rs, exp_d);
        end
        checks++;
        if (high !== 2) begin
            errors++;
            $display("FAIL %s width: EN high %0d cycles, expected 2", name, high);
        end
        $display("pulse %s rs=%0d data=%02h low=%0d high=%0d", name, exp_rs, exp_d, low, high);
    endtask

    task automatic run_init(input int first_low);
        logic [7:0] rom [6];
        int gap;
        rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 6; i++) begin
            gap = (i == 0) ? first_low : ((i == 5) ? 12 : 7);
            pulse_seq(1'b0, rom[i], gap, "init");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tick();
        chip_en = 1'b1;
        register_select = 1'b1;
        #1;
        checks++;
        if (lcd_en !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: en=%0d rs=%0d data=%02h, expected 0 0 00",
                     lcd_en, lcd_rs, lcd_data);
        end
        checks++;
        if (data_out !== 8'h80) begin
            errors++;
            $display("FAIL reset_status: %02h, expected 80", data_out);
        end
        checks++;
        if (lcd_rw !== 1'b0 || lcd_on !== 1'b1) begin
            errors++;
            $display("FAIL constants: rw=%0d on=%0d, expected 0 1", lcd_rw, lcd_on);
        end
        chip_en = 1'b0;
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL deselect_status: %02h, expected 00", data_out);
        end
        $display("reset status=80 outputs idle");
        reset = 1'b0;
    endtask

    task automatic test_init();
        run_init(22);
        chip_en = 1'b1;
        register_select = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h80) begin
            errors++;
            $display("FAIL init_busy: %02h, expected 80", data_out);
        end
        chip_en = 1'b0;
    endtask

    task automatic test_mixed();
        bus_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h41);
        chip_en = 1'b1;
        register_select = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h82) begin
            errors++;
            $display("FAIL mixed_count2: %02h, expected 82", data_out);
        end
        chip_en = 1'b0;
        pulse_seq(1'b0, 8'h80, 5, "cmd80");
        chip_en = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h81) begin
            errors++;
            $display("FAIL mixed_count1: %02h, expected 81", data_out);
        end
        chip_en = 1'b0;
        pulse_seq(1'b1, 8'h41, 7, "data41");
        chip_en = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h80) begin
            errors++;
            $display("FAIL mixed_count0: %02h, expected 80", data_out);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL idle_status: %02h, expected 00", data_out);
        end
        chip_en = 1'b0;
    endtask

    task automatic test_clear_wait();
        int n;
        bus_write(1'b0, 8'h02);
        bus_write(1'b1, 8'h01);
        pulse_seq(1'b0, 8'h02, 1, "cmd02");
        pulse_seq(1'b1, 8'h01, 12, "data01");
        chip_en = 1'b1;
        register_select = 1'b1;
        #1;
        n = 0;
        while (data_out[7] === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL data01_wait: busy %0d cycles after pulse, expected 5", n);
        end
        $display("clear_wait data01 busy_after=%0d", n);
        chip_en = 1'b0;
    endtask

    task automatic test_overflow();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) bus_write(1'b1, 8'h10 + 8'(i));
        chip_en = 1'b1;
        wrt_en = 1'b0;
        register_select = 1'b0;
        #1;
        checks++;
        if (data_out !== 8'hE4) begin
            errors++;
            $display("FAIL overflow_status: %02h, expected E4", data_out);
        end
        tick();
        register_select = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'hC4) begin
            errors++;
            $display("FAIL overflow_cleared: %02h, expected C4", data_out);
        end
        chip_en = 1'b0;
        $display("overflow E4 then C4 after status read");
        run_init(16);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 5; i++) tick();
        chip_en = 1'b1;
        register_select = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'hC4) begin
            errors++;
            $display("FAIL full_idle: %02h, expected C4", data_out);
        end
        bus_write(1'b1, 8'h55);
        chip_en = 1'b1;
        register_select = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'hC4) begin
            errors++;
            $display("FAIL full_pop_push: %02h, expected C4", data_out);
        end
        chip_en = 1'b0;
        pulse_seq(1'b1, 8'h10, 1, "data10");
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        n = 0;
        while (lcd_en !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (lcd_en !== 1'b1 || lcd_data !== 8'h11 || lcd_rs !== 1'b1) begin
            errors++;
            $display("FAIL second_pop: en=%0d rs=%0d data=%02h, expected 1 1 11",
                     lcd_en, lcd_rs, lcd_data);
        end
        reset = 1'b1;
        tick();
        chip_en = 1'b1;
        register_select = 1'b1;
        #1;
        checks++;
        if (lcd_en !== 1'b0 || lcd_data !== 8'h00 || lcd_rs !== 1'b0) begin
            errors++;
            $display("FAIL midpulse_reset: en=%0d rs=%0d data=%02h, expected 0 0 00",
                     lcd_en, lcd_rs, lcd_data);
        end
        checks++;
        if (data_out !== 8'h80) begin
            errors++;
            $display("FAIL midpulse_status: %02h, expected 80", data_out);
        end
        chip_en = 1'b0;
        reset = 1'b0;
        $display("reset mid-pulse en dropped, fifo empty");
        run_init(22);
        for (int i = 0; i < 5; i++) tick();
        chip_en = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reinit_idle: %02h, expected 00", data_out);
        end
        chip_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_mixed();
        test_clear_wait();
        test_overflow();
        test_full_pop();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
